// File: rtl/nice_rb_pkg.sv
// rtl/nice_rb_pkg.sv - shared op codes, states and field layout for the result buffer
//
// Holds the command op codes, FSM state encoding, FIFO entry width and the
// bit positions of the STATUS response word.

package nice_rb_pkg;

   localparam int RES_W   = 5;
   localparam int SEQ_W   = 8;
   localparam int ENTRY_W = SEQ_W + RES_W;   // {seq, result} = 13 bits

   typedef enum logic [1:0] {
      OP_START  = 2'd0,
      OP_READ   = 2'd1,
      OP_STATUS = 2'd2,
      OP_STOP   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RSP  = 2'd2
   } state_e;

   // STATUS word layout
   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_COUNT_W   = 4;
   localparam int STAT_EMPTY_BIT = 7;
   localparam int STAT_FULL_BIT  = 8;
   localparam int STAT_OVF_BIT   = 9;

   // READ payload: entry right-aligned, upper bits zero
   function automatic logic [31:0] read_payload(input logic [ENTRY_W-1:0] entry);
      return {{(32-ENTRY_W){1'b0}}, entry};
   endfunction

endpackage

// File: rtl/nice_result_fifo.sv
// rtl/nice_result_fifo.sv - synchronous DEPTH x 13-bit result FIFO
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   push, din      write request and entry
//   pop            remove head (ignored when empty)
//   flush          empty the FIFO; a push in the same cycle is discarded
//   dout           combinational head entry
//   full, empty    occupancy flags
//   count          number of stored entries (0..DEPTH)

module nice_result_fifo
   import nice_rb_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic               full,
   output logic               empty,
   output logic [CW-1:0]      count
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A push on a full FIFO still lands when a pop frees the head slot in the
   // same cycle; the write and read pointers then both advance.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define which slots are valid.
   always_ff @(posedge i_clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/nice_result_buffer.sv
// rtl/nice_result_buffer.sv - CNN result FIFO with CPU req/rsp command port
//
// Captures classification results from the CNN core into a sequence-tagged
// FIFO and serves START/STOP/READ/STATUS commands from the CPU side. READ on
// an empty FIFO blocks until a result arrives or TIMEOUT cycles elapse.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_result_data/i_result_valid  result strobe from the core
//   o_start                       level enable to the core
//   i_req_valid/o_req_ready/i_req_op   command request handshake
//   o_rsp_valid/i_rsp_ready/o_rsp_data/o_rsp_err   response handshake
//   o_overflow                    sticky: a result was dropped on a full FIFO

module nice_result_buffer
   import nice_rb_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 65535
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_result_data,
   input  logic        i_result_valid,
   output logic        o_start,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [1:0]  i_req_op,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic        o_rsp_err,
   output logic        o_overflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_e             state;
   state_e             state_next;
   op_e                op;
   logic [SEQ_W-1:0]   seq;
   logic [TW-1:0]      timer;
   logic [TW-1:0]      timer_next;
   logic               start_next;
   logic [31:0]        rsp_data_next;
   logic               rsp_err_next;
   logic [31:0]        status_word;

   logic               fifo_pop;
   logic               fifo_flush;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;

   nice_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (i_result_valid),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   ({seq, i_result_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign op          = op_e'(i_req_op);
   assign o_req_ready = (state == S_IDLE);
   assign o_rsp_valid = (state == S_RSP);

   always_comb begin
      status_word = '0;
      status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      status_word[STAT_EMPTY_BIT] = fifo_empty;
      status_word[STAT_FULL_BIT]  = fifo_full;
      status_word[STAT_OVF_BIT]   = o_overflow;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         o_start    <= 1'b0;
         o_rsp_data <= '0;
         o_rsp_err  <= 1'b0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         o_start    <= start_next;
         o_rsp_data <= rsp_data_next;
         o_rsp_err  <= rsp_err_next;
      end
   end

   always_comb begin
      state_next    = state;
      timer_next    = timer;
      start_next    = o_start;
      rsp_data_next = o_rsp_data;
      rsp_err_next  = o_rsp_err;
      fifo_pop      = 1'b0;
      fifo_flush    = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_req_valid) begin
               case (op)
                  OP_START: begin
                     start_next    = 1'b1;
                     rsp_data_next = '0;
                     state_next    = S_RSP;
                  end
                  OP_STOP: begin
                     start_next    = 1'b0;
                     fifo_flush    = 1'b1;
                     rsp_data_next = '0;
                     state_next    = S_RSP;
                  end
                  OP_STATUS: begin
                     rsp_data_next = status_word;
                     state_next    = S_RSP;
                  end
                  OP_READ: begin
                     if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        rsp_data_next = read_payload(fifo_dout);
                        state_next    = S_RSP;
                     end else begin
                        timer_next = '0;
                        state_next = S_WAIT;
                     end
                  end
                  default: state_next = S_IDLE;
               endcase
            end
         end
         S_WAIT: begin
            // A result arriving now is only visible next cycle, so the wait
            // loop keys off the registered empty flag.
            if (!fifo_empty) begin
               fifo_pop      = 1'b1;
               rsp_data_next = read_payload(fifo_dout);
               rsp_err_next  = 1'b0;
               state_next    = S_RSP;
            end else if (timer == TIMER_LAST) begin
               rsp_err_next  = 1'b1;
               rsp_data_next = '0;
               state_next    = S_RSP;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         S_RSP: begin
            if (i_rsp_ready) begin
               rsp_err_next = 1'b0;
               state_next   = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Sequence tags advance on every strobe, dropped or not; STOP restarts them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         seq        <= '0;
         o_overflow <= 1'b0;
      end else if (fifo_flush) begin
         seq        <= '0;
         o_overflow <= 1'b0;
      end else if (i_result_valid) begin
         seq <= seq + 1'b1;
         if (fifo_full && !fifo_pop) o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nice_result_buffer.sv
// tb/tb_nice_result_buffer.sv - self-checking bench for nice_result_buffer

module tb_nice_result_buffer;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 16;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [4:0]  i_result_data = '0;
   logic        i_result_valid = 1'b0;
   logic        o_start;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [1:0]  i_req_op = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;
   logic        o_overflow;

   int checks = 0;
   int errors = 0;

   nice_result_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_result_data  (i_result_data),
      .i_result_valid (i_result_valid),
      .o_start        (o_start),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_op       (i_req_op),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_data     (o_rsp_data),
      .o_rsp_err      (o_rsp_err),
      .o_overflow     (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: a queue of {seq,result} entries plus the command phase
   // (0 idle, 1 blocked read, 2 response pending).
   logic [12:0] mq[$];
   logic [7:0]  mseq;
   logic        movf;
   logic        mstart;
   int          mphase;
   int          wcnt;
   logic [31:0] mexp;
   logic        merr;

   task automatic model_reset();
      mq.delete();
      mseq = 0; movf = 0; mstart = 0; mphase = 0; wcnt = 0; mexp = 0; merr = 0;
   endtask

   task automatic model_step(input logic req, input logic [1:0] op, input logic push,
                             input logic [4:0] d, input logic rdy);
      int sz;
      bit popd;
      bit flush;
      sz = mq.size();
      popd = 0;
      flush = 0;
      case (mphase)
         0: if (req) begin
            case (op)
               2'd0: begin mstart = 1; mexp = 0; mphase = 2; end
               2'd3: begin mstart = 0; flush = 1; mexp = 0; mphase = 2; end
               2'd2: begin
                  mexp = 32'(sz);
                  mexp[7] = (sz == 0);
                  mexp[8] = (sz == DEPTH);
                  mexp[9] = movf;
                  mphase = 2;
               end
               default: begin
                  if (sz > 0) begin mexp = {19'd0, mq[0]}; popd = 1; mphase = 2; end
                  else begin mphase = 1; wcnt = 0; end
               end
            endcase
         end
         1: begin
            if (sz > 0) begin mexp = {19'd0, mq[0]}; popd = 1; merr = 0; mphase = 2; end
            else if (wcnt == TIMEOUT - 1) begin merr = 1; mexp = 0; mphase = 2; end
            else wcnt++;
         end
         default: if (rdy) begin mphase = 0; merr = 0; end
      endcase
      if (flush) begin
         mq.delete(); mseq = 0; movf = 0;
      end else begin
         if (popd) void'(mq.pop_front());
         if (push) begin
            if (sz == DEPTH && !popd) movf = 1;
            else mq.push_back({mseq, d});
            mseq++;
         end
      end
   endtask

   task automatic tick(input logic req, input logic [1:0] op, input logic push,
                       input logic [4:0] d, input logic rdy);
      i_req_valid = req; i_req_op = op; i_result_valid = push; i_result_data = d;
      i_rsp_ready = rdy;
      model_step(req, op, push, d, rdy);
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_req_valid = 0; i_result_valid = 0; i_rsp_ready = 0;
      model_reset();
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start"},    32'(o_start),     32'd0);
      chk({tag, "_ready"},    32'(o_req_ready), 32'd1);
      chk({tag, "_rsp_valid"},32'(o_rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, o_rsp_data,       32'd0);
      chk({tag, "_rsp_err"},  32'(o_rsp_err),   32'd0);
      chk({tag, "_overflow"}, 32'(o_overflow),  32'd0);
   endtask

   typedef struct {
      logic        req;
      logic [1:0]  op;
      logic        push;
      logic [4:0]  pd;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic        es;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n;
      // ---------------- table-driven basic sequence ----------------
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h000, 1'b1};
      tbl[1]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h000, 1'b1};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b1, 32'h080, 1'b1};
      tbl[3]  = '{1'b0, 2'd0, 1'b1, 5'd3, 1'b1, 1'b0, 32'h080, 1'b1};
      tbl[4]  = '{1'b0, 2'd0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h080, 1'b1};
      tbl[5]  = '{1'b0, 2'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h080, 1'b1};
      tbl[6]  = '{1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h003, 1'b1};
      tbl[7]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h003, 1'b1};
      tbl[8]  = '{1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h027, 1'b1};
      tbl[9]  = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h027, 1'b1};
      tbl[10] = '{1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h049, 1'b1};
      tbl[11] = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h049, 1'b1};
      tbl[12] = '{1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b1, 32'h080, 1'b1};
      tbl[13] = '{1'b0, 2'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h080, 1'b1};

      do_reset();
      chk_reset_outputs("reset");
      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].req, tbl[i].op, tbl[i].push, tbl[i].pd, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), 32'(o_rsp_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_ready", i), 32'(o_req_ready), 32'(!tbl[i].ev));
         chk($sformatf("tbl%0d_data", i),  o_rsp_data, tbl[i].ed);
         chk($sformatf("tbl%0d_start", i), 32'(o_start), 32'(tbl[i].es));
      end

      // ---------------- READ timeout on empty ----------------
      tick(1, 2'd1, 0, 0, 0);
      n = 1;
      while (!o_rsp_valid && n < 40) begin
         chk("wait_ready_low", 32'(o_req_ready), 32'd0);
         tick(0, 0, 0, 0, 0);
         n++;
      end
      chk("timeout_latency", 32'(n), 32'd17);
      chk("timeout_err", 32'(o_rsp_err), 32'd1);
      chk("timeout_data", o_rsp_data, 32'd0);
      tick(0, 0, 0, 0, 1);
      chk("timeout_err_clr", 32'(o_rsp_err), 32'd0);

      // ---------------- blocking READ satisfied by a push ----------------
      tick(1, 2'd1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 5'd5, 0);
      chk("blk_not_yet", 32'(o_rsp_valid), 32'd0);
      tick(0, 0, 0, 0, 0);
      chk("blk_valid", 32'(o_rsp_valid), 32'd1);
      chk("blk_data", o_rsp_data, 32'h065);
      chk("blk_err", 32'(o_rsp_err), 32'd0);
      tick(0, 0, 0, 0, 1);

      // ---------------- fill, overflow, push+pop on full ----------------
      for (int i = 0; i < 9; i++) tick(0, 0, 1, 5'(i + 1), 0);
      chk("ovf_set", 32'(o_overflow), 32'd1);
      tick(1, 2'd2, 0, 0, 0);
      chk("status_full", o_rsp_data, 32'h308);
      tick(0, 0, 0, 0, 1);
      tick(1, 2'd1, 1, 5'd20, 0);
      chk("full_rw_data", o_rsp_data, 32'h081);
      chk("full_rw_ovf", 32'(o_overflow), 32'd1);
      tick(0, 0, 0, 0, 1);
      tick(1, 2'd2, 0, 0, 0);
      chk("status_full2", o_rsp_data, 32'h308);

      // ---------------- response back-pressure ----------------
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, 1, 5'(i), 0);
         chk("hold_valid", 32'(o_rsp_valid), 32'd1);
         chk("hold_data", o_rsp_data, 32'h308);
         chk("hold_ready", 32'(o_req_ready), 32'd0);
      end
      tick(0, 0, 0, 0, 1);

      // ---------------- STOP flushes and restarts sequence ----------------
      tick(1, 2'd3, 1, 5'd11, 0);
      chk("stop_valid", 32'(o_rsp_valid), 32'd1);
      chk("stop_data", o_rsp_data, 32'd0);
      chk("stop_start", 32'(o_start), 32'd0);
      chk("stop_ovf", 32'(o_overflow), 32'd0);
      tick(0, 0, 0, 0, 1);
      tick(1, 2'd2, 0, 0, 0);
      chk("stop_status", o_rsp_data, 32'h080);
      tick(0, 0, 1, 5'd2, 1);
      tick(1, 2'd1, 0, 0, 0);
      chk("stop_seq0", o_rsp_data, 32'h002);
      tick(0, 0, 0, 0, 1);

      // ---------------- async reset in WAIT and in RSP ----------------
      tick(1, 2'd0, 0, 0, 0);
      tick(0, 0, 0, 0, 1);
      tick(1, 2'd1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      chk("pre_rst_start", 32'(o_start), 32'd1);
      #2 i_rst = 1'b1;
      #1 chk_reset_outputs("rst_wait");
      model_reset();
      i_rst = 1'b0;
      tick(1, 2'd0, 1, 5'd4, 0);
      chk("pre_rst_rsp", 32'(o_rsp_valid), 32'd1);
      #2 i_rst = 1'b1;
      #1 chk_reset_outputs("rst_rsp");
      model_reset();
      i_rst = 1'b0;
      tick(1, 2'd2, 0, 0, 0);
      chk("rst_status", o_rsp_data, 32'h080);
      tick(0, 0, 0, 0, 1);

      // ---------------- randomized run against the model ----------------
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic req;
         logic [1:0] op;
         int r;
         req = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 15);
         op = (r == 0) ? 2'd3 : (r < 3) ? 2'd0 : (r < 6) ? 2'd2 : 2'd1;
         tick(req, op, ($urandom_range(0, 3) == 0), 5'($urandom), ($urandom_range(0, 3) != 0));
         chk("rnd_valid", 32'(o_rsp_valid), 32'(mphase == 2));
         chk("rnd_ready", 32'(o_req_ready), 32'(mphase == 0));
         chk("rnd_data",  o_rsp_data, mexp);
         chk("rnd_err",   32'(o_rsp_err), 32'(merr));
         chk("rnd_start", 32'(o_start), 32'(mstart));
         chk("rnd_ovf",   32'(o_overflow), 32'(movf));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nice_result_buffer.md
Name: nice_result_buffer

Overview:
- Sits directly downstream of the CNN core, consuming its 5-bit classification result and valid pulse.
- Buffers results in a small FIFO, each tagged with an 8-bit sequence number.
- Serves the CPU-side custom-instruction path through a req/rsp handshake: START/STOP the core (drives its i_start level), READ one result, or read STATUS.
- Supports blocking READ with a timeout, so software can wait for an inference result.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
TIMEOUT, 65535, cycles a READ on empty waits before error response
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
i_clk  in  1  core clock (same domain as core PE_clk)
i_rst  in  1  asynchronous active-high reset
i_result_data  in  5  classification result from core
i_result_valid  in  1  one-cycle strobe, result present
o_start  out  1  level enable to core i_start
i_req_valid  in  1  command request valid
o_req_ready  out  1  command accepted when valid&ready
i_req_op  in  2  0=START, 1=READ, 2=STATUS, 3=STOP
o_rsp_valid  out  1  response valid, held until accepted
i_rsp_ready  in  1  response consumer ready
o_rsp_data  out  32  response payload
o_rsp_err  out  1  READ timed out (payload 0)
o_overflow  out  1  sticky: result dropped on full FIFO

Behaviour:
- Reset (async assert, release on i_clk): o_start=0, o_req_ready=1, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_overflow=0, FIFO empty, seq=0, timer=0, state IDLE.
- Capture: each i_result_valid pushes {seq, i_result_data}; seq increments (8-bit, wraps 255->0) on every strobe, including dropped ones. Push happens regardless of state.
- Full & push & no pop: entry dropped, o_overflow<=1. Full & push & pop in the same cycle: both occur, no overflow. Push & pop while not full: count unchanged.
- FSM states:
  - IDLE: o_req_ready=1; the request handshake completes on i_req_valid & o_req_ready.
  - WAIT: o_req_ready=0.
  - RSP: o_req_ready=0.
- IDLE transitions on an accepted request (all go to RSP except the READ-on-empty case):
  - START: o_start<=1; rsp_data=0.
  - STOP: o_start<=0; FIFO flushed; seq<=0; o_overflow<=0. A push in that same cycle is discarded. rsp_data=0.
  - STATUS: rsp_data={22'd0, o_overflow, full, empty, 3'd0, count zero-extended to 4 bits}, i.e. count in [3:0], empty in [7], full in [8], overflow in [9]. Values are sampled pre-update in the acceptance cycle.
  - READ, FIFO non-empty: pop head; rsp_data={19'd0, seq[7:0], result[4:0]}.
  - READ, FIFO empty: go to WAIT with timer<=0.
- WAIT:
  - FIFO non-empty (including a push arriving this cycle, visible next cycle): pop head, build READ payload, go to RSP.
  - Else, timer==TIMEOUT-1: rsp_err<=1, rsp_data<=0, go to RSP.
  - Else: timer++.
- RSP: o_rsp_valid=1, payload stable. On i_rsp_ready, go to IDLE and clear o_rsp_valid/o_rsp_err next cycle.
- Latency:
  - Accepted non-blocking request -> o_rsp_valid on the next cycle.
  - READ on empty: the push cycle -> WAIT pops on the next cycle -> rsp_valid one cycle later.
  - Minimum back-to-back throughput is 1 command per 2 cycles.
- Reset mid-operation: everything returns to reset values immediately; an in-flight response is lost.

Decomposition:
- Package nice_rb_pkg holds:
  - Op codes OP_START/OP_READ/OP_STATUS/OP_STOP.
  - State encoding S_IDLE/S_WAIT/S_RSP.
  - Entry width constant (13).
  - STATUS bit-position constants.
- Sub-module nice_result_fifo: sync FIFO, DEPTH x 13 bits.
  - Ports: push, pop, flush, din, dout (combinational head), full, empty, count.
  - Implements the simultaneous push/pop-on-full rule.
- Top holds the FSM, timer, seq counter, o_start, and overflow logic.

Test Plan:
- Reset, then START -> one-cycle-later rsp_valid, rsp_data=0, o_start=1. STATUS -> rsp_data=0x80 (empty, count 0).
- Push results 3,7,9 -> three READs return 0x003, 0x027, 0x049 (seq 0,1,2); a fourth READ with TIMEOUT=16 -> after 16 WAIT cycles rsp_err=1, data=0.
- READ on empty, then push result 5 at cycle 4 of WAIT -> rsp_valid 2 cycles after the push, data={seq,5}, err=0.
- Fill DEPTH=8, push a 9th -> overflow=1, STATUS=0x308; push and READ simultaneously on full -> count stays 8, overflow unchanged.
- Hold i_rsp_ready=0 for 10 cycles -> rsp_valid/payload stable, o_req_ready=0, pushes still captured; then STOP -> count 0, overflow 0, seq restarts at 0, o_start=0.
- Assert i_rst while in WAIT and in RSP -> all outputs reach reset values asynchronously, before the next edge.
